// File: rtl/intersection_sequencer_pkg.sv
// Shared phase encoding, pedestrian light codes and per-phase service masks
// for the intersection sequencer and pedestrian_crossing.
package intersection_sequencer_pkg;

    localparam int unsigned PHASE_W = 5;
    localparam int unsigned DIR_W   = 4;

    typedef enum logic [PHASE_W-1:0] {
        N_S     = 5'd0,
        E_W     = 5'd1,
        N_S_Y   = 5'd2,
        E_W_Y   = 5'd3,
        N_NL    = 5'd4,
        N_NL_Y  = 5'd5,
        S_SL    = 5'd6,
        S_SL_Y  = 5'd7,
        W_WL    = 5'd8,
        W_WL_Y  = 5'd9,
        E_EL    = 5'd10,
        E_EL_Y  = 5'd11,
        SL_NL   = 5'd12,
        SL_NL_Y = 5'd13,
        EL_WL   = 5'd14,
        EL_WL_Y = 5'd15
    } phase_e;

    typedef enum logic [1:0] {
        PED_OFF         = 2'd0,
        PED_WALKING_MAN = 2'd1,
        PED_RED_HAND    = 2'd2
    } ped_light_e;

    // Pedestrian crossings {w,e,s,n} a green serves; yellows serve none.
    function automatic logic [DIR_W-1:0] served_crossings(input phase_e p);
        case (p)
            N_S:     return 4'b1100;
            E_W:     return 4'b0011;
            N_NL:    return 4'b1000;
            S_SL:    return 4'b0100;
            W_WL:    return 4'b0010;
            E_EL:    return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    // Left lanes {wl,el,sl,nl} a left green or its yellow is serving.
    function automatic logic [DIR_W-1:0] served_lanes(input phase_e p);
        case (p)
            N_NL, N_NL_Y:   return 4'b0001;
            S_SL, S_SL_Y:   return 4'b0010;
            E_EL, E_EL_Y:   return 4'b0100;
            W_WL, W_WL_Y:   return 4'b1000;
            SL_NL, SL_NL_Y: return 4'b0011;
            EL_WL, EL_WL_Y: return 4'b1100;
            default:        return 4'b0000;
        endcase
    endfunction

    function automatic logic is_green(input phase_e p);
        case (p)
            N_S, E_W, N_NL, S_SL, W_WL, E_EL, SL_NL, EL_WL: return 1'b1;
            default:                                        return 1'b0;
        endcase
    endfunction

    function automatic logic is_through(input phase_e p);
        return (p == N_S) || (p == E_W);
    endfunction

    function automatic phase_e ew_decision(input logic [DIR_W-1:0] left);
        if (left[2] && left[3]) return EL_WL;
        if (left[2])            return E_EL;
        if (left[3])            return W_WL;
        return E_W;
    endfunction

    function automatic phase_e ns_decision(input logic [DIR_W-1:0] left);
        if (left[0] && left[1]) return SL_NL;
        if (left[0])            return N_NL;
        if (left[1])            return S_SL;
        return N_S;
    endfunction

endpackage

// File: rtl/intersection_sequencer_if.sv
// Sensor/button inputs and phase/latch outputs of the intersection sequencer.
interface intersection_sequencer_if
    import intersection_sequencer_pkg::*;
#(
    parameter int unsigned TW = 8
);
    logic               tick;
    logic               cs_nl;
    logic               cs_sl;
    logic               cs_el;
    logic               cs_wl;
    logic               psn;
    logic               pss;
    logic               pse;
    logic               psw;
    logic [PHASE_W-1:0] state1;
    logic [DIR_W-1:0]   left_req;
    logic [DIR_W-1:0]   ped_pend;
    logic [TW-1:0]      timer;

    modport master (
        output tick, cs_nl, cs_sl, cs_el, cs_wl, psn, pss, pse, psw,
        input  state1, left_req, ped_pend, timer
    );

    modport slave (
        input  tick, cs_nl, cs_sl, cs_el, cs_wl, psn, pss, pse, psw,
        output state1, left_req, ped_pend, timer
    );
endinterface

// File: rtl/intersection_sequencer_phase_timer.sv
// Tick-driven phase timer: counts ticks and flags the tick that ends the phase.
module intersection_sequencer_phase_timer #(
    parameter int unsigned TW = 8
) (
    input  logic          clk,
    input  logic          i_clear,
    input  logic          i_tick,
    input  logic [TW:0]   i_dur,
    output logic [TW-1:0] o_count,
    output logic          o_done_c
);
    localparam int unsigned DW = TW + 1;

    logic [TW-1:0] r_count;

    // Duration may grow mid-phase; >= keeps a shrunken duration from wrapping.
    assign o_done_c = i_tick && (DW'(r_count) >= (i_dur - DW'(1)));
    assign o_count  = r_count;

    always_ff @(posedge clk) begin
        if (i_clear) begin
            r_count <= '0;
        end else if (i_tick) begin
            r_count <= o_done_c ? '0 : r_count + TW'(1);
        end
    end

endmodule

// File: rtl/intersection_sequencer.sv
// Actuated intersection phase sequencer: through greens always, protected lefts
// on latched demand, greens extended by latched pedestrian requests.
module intersection_sequencer
    import intersection_sequencer_pkg::*;
#(
    parameter int unsigned TW          = 8,
    parameter int unsigned GREEN_T     = 20,
    parameter int unsigned PED_GREEN_T = 30,
    parameter int unsigned LEFT_T      = 10,
    parameter int unsigned YELLOW_T    = 4
) (
    input  logic                    CLK,
    input  logic                    rst,
    intersection_sequencer_if.slave bus
);
    localparam int unsigned DW = TW + 1;

    phase_e           r_state;
    phase_e           w_state_next;
    logic [DIR_W-1:0] r_left_req;
    logic [DIR_W-1:0] r_ped_pend;
    logic [DIR_W-1:0] w_left_next;
    logic [DIR_W-1:0] w_ped_next;
    logic [DIR_W-1:0] w_cs;
    logic [DIR_W-1:0] w_ps;
    logic [DIR_W-1:0] w_served;
    logic [DW-1:0]    w_dur;
    logic             w_timeout;
    logic [TW-1:0]    w_count;

    assign w_cs     = {bus.cs_wl, bus.cs_el, bus.cs_sl, bus.cs_nl};
    assign w_ps     = {bus.psw, bus.pse, bus.pss, bus.psn};
    assign w_served = served_crossings(r_state);

    intersection_sequencer_phase_timer #(
        .TW (TW)
    ) u_phase_timer (
        .clk      (CLK),
        .i_clear  (rst),
        .i_tick   (bus.tick),
        .i_dur    (w_dur),
        .o_count  (w_count),
        .o_done_c (w_timeout)
    );

    // Duration re-evaluated every cycle so a fresh press stretches the green.
    always_comb begin
        w_dur = DW'(YELLOW_T);
        if (is_green(r_state)) begin
            if ((w_served & r_ped_pend) != '0) begin
                w_dur = DW'(PED_GREEN_T);
            end else if (is_through(r_state)) begin
                w_dur = DW'(GREEN_T);
            end else begin
                w_dur = DW'(LEFT_T);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_timeout) begin
            case (r_state)
                N_S:                      w_state_next = N_S_Y;
                E_W:                      w_state_next = E_W_Y;
                N_S_Y:                    w_state_next = ew_decision(r_left_req);
                E_W_Y:                    w_state_next = ns_decision(r_left_req);
                N_NL:                     w_state_next = N_NL_Y;
                S_SL:                     w_state_next = S_SL_Y;
                W_WL:                     w_state_next = W_WL_Y;
                E_EL:                     w_state_next = E_EL_Y;
                SL_NL:                    w_state_next = SL_NL_Y;
                EL_WL:                    w_state_next = EL_WL_Y;
                N_NL_Y, S_SL_Y, SL_NL_Y:  w_state_next = N_S;
                E_EL_Y, W_WL_Y, EL_WL_Y:  w_state_next = E_W;
                default:                  w_state_next = N_S;
            endcase
        end
    end

    // Lane demand is blanked from the entry edge until the cycle after its yellow.
    assign w_left_next = (r_left_req | (w_cs & ~served_lanes(r_state)))
                       & ~served_lanes(w_state_next);
    // A press on the exit edge re-sets the bit that is being cleared.
    assign w_ped_next  = (r_ped_pend & ~(w_timeout ? w_served : 4'b0000)) | w_ps;

    always_ff @(posedge CLK) begin
        if (rst) begin
            r_state    <= N_S;
            r_left_req <= '0;
            r_ped_pend <= '0;
        end else begin
            r_state    <= w_state_next;
            r_left_req <= w_left_next;
            r_ped_pend <= w_ped_next;
        end
    end

    assign bus.state1   = r_state;
    assign bus.left_req = r_left_req;
    assign bus.ped_pend = r_ped_pend;
    assign bus.timer    = w_count;

endmodule
